// File: rtl/abc_seq_gen_if.sv
// abc_seq_gen_if
//   Groups the request/strobe/status signals of abc_seq_gen.
//   Ports (signals):
//     start     request one a->b->c sequence (one-cycle pulse)
//     a, b, c   registered phase strobes, one-hot
//     busy      sequencer not idle
//     pend_cnt  queued, not-yet-started requests
//     seq_cnt   completed sequences (saturating, CNT_W bits)
//     drop      one-cycle pulse: a start was discarded (queue full)
//   Modports: master (requester side), slave (sequencer side).
interface abc_seq_gen_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             a;
    logic             b;
    logic             c;
    logic             busy;
    logic [3:0]       pend_cnt;
    logic [CNT_W-1:0] seq_cnt;
    logic             drop;

    modport master (
        output start,
        input  a, b, c, busy, pend_cnt, seq_cnt, drop
    );

    modport slave (
        input  start,
        output a, b, c, busy, pend_cnt, seq_cnt, drop
    );
endinterface

// File: rtl/abc_seq_gen.sv
// abc_seq_gen
//   Generates one-cycle a, b, c strobes in sequence for every start request.
//   Requests arriving while a sequence runs are queued (up to PEND_MAX);
//   starts beyond that are discarded and flagged on drop.
//   Ports:
//     clk      single clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      abc_seq_gen_if.slave (start in; a/b/c/busy/pend_cnt/seq_cnt/drop out)
//   Parameters:
//     PEND_MAX  queue depth, 1..15
//     CNT_W     width of the completed-sequence counter
//   Build option:
//     ABC_SEQ_BACK2BACK_EN  when defined, PH_C chains straight into PH_A if
//                           another request is waiting; otherwise there is
//                           always at least one IDLE cycle between sequences.
//
//   state | meaning
//   ------+--------------------------------------------
//   IDLE  | no sequence running, waiting for a trigger
//   PH_A  | a strobe high
//   PH_B  | b strobe high
//   PH_C  | c strobe high, sequence completes on exit
module abc_seq_gen #(
    parameter int PEND_MAX = 3,
    parameter int CNT_W    = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    abc_seq_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH_A = 2'd1,
        PH_B = 2'd2,
        PH_C = 2'd3
    } state_t;

    localparam logic [3:0] PEND_MAX_L = 4'(PEND_MAX);

    state_t           state_q;
    state_t           state_d;
    logic             launch;
    logic             pend_nz;
    logic             deq;
    logic             enq;
    logic             enq_acc;
    logic             drop_d;
    logic [3:0]       pend_q;
    logic [3:0]       pend_d;
    logic [CNT_W-1:0] seq_q;
    logic [CNT_W-1:0] seq_d;
    logic             a_q;
    logic             b_q;
    logic             c_q;
    logic             busy_q;
    logic             drop_q;

    assign pend_nz = (pend_q != 4'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pend_q  <= 4'd0;
            seq_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            seq_q   <= seq_d;
            // Strobes are registered from the next state so they line up
            // exactly with the state they represent.
            a_q     <= (state_d == PH_A);
            b_q     <= (state_d == PH_B);
            c_q     <= (state_d == PH_C);
            busy_q  <= (state_d != IDLE);
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start || pend_nz) begin
                    state_d = PH_A;
                    launch  = 1'b1;
                end
            end
            PH_A: state_d = PH_B;
            PH_B: state_d = PH_C;
            PH_C: begin
`ifdef ABC_SEQ_BACK2BACK_EN
                if (bus.start || pend_nz) begin
                    state_d = PH_A;
                    launch  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // A launch is served from the queue first; only when the queue is empty
    // does a same-cycle start get consumed directly. Any other start is an
    // enqueue attempt, which succeeds if there is room or a slot is being
    // freed by the dequeue in the same cycle.
    always_comb begin
        deq     = launch && pend_nz;
        enq     = bus.start && !(launch && !pend_nz);
        enq_acc = enq && ((pend_q < PEND_MAX_L) || deq);
        drop_d  = enq && !enq_acc;
        pend_d  = pend_q;
        if (enq_acc && !deq) begin
            pend_d = pend_q + 4'd1;
        end else if (!enq_acc && deq) begin
            pend_d = pend_q - 4'd1;
        end
    end

    always_comb begin
        seq_d = seq_q;
        if ((state_q == PH_C) && (seq_q != {CNT_W{1'b1}})) begin
            seq_d = seq_q + 1'b1;
        end
    end

    assign bus.a        = a_q;
    assign bus.b        = b_q;
    assign bus.c        = c_q;
    assign bus.busy     = busy_q;
    assign bus.pend_cnt = pend_q;
    assign bus.seq_cnt  = seq_q;
    assign bus.drop     = drop_q;

endmodule

// File: tb/tb_abc_seq_gen.sv
module tb_abc_seq_gen;

    logic clk;
    logic reset_n;
    int   nvec;
    int   nfail;

    abc_seq_gen_if #(.CNT_W(8)) bus ();
    abc_seq_gen_if #(.CNT_W(2)) bus2 ();

    abc_seq_gen #(.PEND_MAX(3), .CNT_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    abc_seq_gen #(.PEND_MAX(3), .CNT_W(2)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus2.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Drive start for one cycle and land 1 time unit after the sampling edge.
    task automatic cyc(input logic s);
        bus.start = s;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++; if (bus.a !== 1'b0) begin nfail++; $display("FAIL reset_a: got %b expected 0", bus.a); end
        nvec++; if (bus.b !== 1'b0) begin nfail++; $display("FAIL reset_b: got %b expected 0", bus.b); end
        nvec++; if (bus.c !== 1'b0) begin nfail++; $display("FAIL reset_c: got %b expected 0", bus.c); end
        nvec++; if (bus.busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        nvec++; if (bus.drop !== 1'b0) begin nfail++; $display("FAIL reset_drop: got %b expected 0", bus.drop); end
        nvec++; if (bus.pend_cnt !== 4'd0) begin nfail++; $display("FAIL reset_pend: got %0d expected 0", bus.pend_cnt); end
        nvec++; if (bus.seq_cnt !== 8'd0) begin nfail++; $display("FAIL reset_seq: got %0d expected 0", bus.seq_cnt); end
    endtask

    task automatic test_single();
        logic [2:0] exp_abc[4];
        logic       exp_busy[4];
        int         exp_seq[4];
        exp_abc  = '{3'b100, 3'b010, 3'b001, 3'b000};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0};
        exp_seq  = '{0, 0, 0, 1};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(k == 0);
            nvec++;
            if ({bus.a, bus.b, bus.c} !== exp_abc[k]) begin
                nfail++; $display("FAIL single_abc[%0d]: got %b expected %b", k, {bus.a, bus.b, bus.c}, exp_abc[k]);
            end
            nvec++;
            if (bus.busy !== exp_busy[k]) begin
                nfail++; $display("FAIL single_busy[%0d]: got %b expected %b", k, bus.busy, exp_busy[k]);
            end
            nvec++;
            if (bus.seq_cnt !== 8'(exp_seq[k]) || bus.pend_cnt !== 4'd0) begin
                nfail++; $display("FAIL single_cnt[%0d]: got seq %0d pend %0d expected seq %0d pend 0", k, bus.seq_cnt, bus.pend_cnt, exp_seq[k]);
            end
        end
    endtask

    task automatic test_queue();
        int peak;
        int exp_peak;
`ifdef ABC_SEQ_BACK2BACK_EN
        exp_peak = 2;
`else
        exp_peak = 3;
`endif
        peak = 0;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            cyc(k < 4);
            if (int'(bus.pend_cnt) > peak) peak = int'(bus.pend_cnt);
            nvec++;
            if (bus.drop !== 1'b0) begin
                nfail++; $display("FAIL queue_drop[%0d]: got %b expected 0", k, bus.drop);
            end
        end
        nvec++;
        if (peak != exp_peak) begin nfail++; $display("FAIL queue_peak: got %0d expected %0d", peak, exp_peak); end
        nvec++;
        if (bus.seq_cnt !== 8'd4) begin nfail++; $display("FAIL queue_seq: got %0d expected 4", bus.seq_cnt); end
        nvec++;
        if (bus.pend_cnt !== 4'd0 || bus.busy !== 1'b0) begin
            nfail++; $display("FAIL queue_idle: got pend %0d busy %b expected pend 0 busy 0", bus.pend_cnt, bus.busy);
        end
    endtask

    task automatic test_drop();
        int   exp_p[9];
        logic exp_d[9];
`ifdef ABC_SEQ_BACK2BACK_EN
        exp_p = '{0, 1, 2, 2, 3, 3, 3, 3, 3};
        exp_d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_p = '{0, 1, 2, 3, 3, 3, 3, 3, 2};
        exp_d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
        do_reset();
        for (int k = 0; k < 9; k++) begin
            cyc(k < 8);
            nvec++;
            if (bus.pend_cnt !== 4'(exp_p[k])) begin
                nfail++; $display("FAIL drop_pend[%0d]: got %0d expected %0d", k, bus.pend_cnt, exp_p[k]);
            end
            nvec++;
            if (bus.drop !== exp_d[k]) begin
                nfail++; $display("FAIL drop_pulse[%0d]: got %b expected %b", k, bus.drop, exp_d[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_gap_a;
        logic exp_next_b;
`ifdef ABC_SEQ_BACK2BACK_EN
        exp_gap_a  = 1'b1;
        exp_next_b = 1'b1;
`else
        exp_gap_a  = 1'b0;
        exp_next_b = 1'b0;
`endif
        do_reset();
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
        nvec++;
        if (bus.c !== 1'b1 || bus.pend_cnt !== 4'd2) begin
            nfail++; $display("FAIL b2b_c: got c %b pend %0d expected c 1 pend 2", bus.c, bus.pend_cnt);
        end
        cyc(1'b0);
        nvec++;
        if (bus.a !== exp_gap_a || bus.busy !== exp_gap_a) begin
            nfail++; $display("FAIL b2b_gap: got a %b busy %b expected %b", bus.a, bus.busy, exp_gap_a);
        end
        cyc(1'b0);
        nvec++;
        if (bus.a !== !exp_next_b || bus.b !== exp_next_b) begin
            nfail++; $display("FAIL b2b_next: got a %b b %b expected a %b b %b", bus.a, bus.b, !exp_next_b, exp_next_b);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(1'b1);
        repeat (3) cyc(1'b0);
        cyc(1'b1);
        cyc(1'b1);
        nvec++;
        if (bus.b !== 1'b1 || bus.seq_cnt !== 8'd1 || bus.pend_cnt !== 4'd1) begin
            nfail++; $display("FAIL rmid_pre: got b %b seq %0d pend %0d expected b 1 seq 1 pend 1", bus.b, bus.seq_cnt, bus.pend_cnt);
        end
        #2;
        reset_n = 1'b0;
        #1;
        nvec++;
        if ({bus.a, bus.b, bus.c, bus.busy} !== 4'b0000) begin
            nfail++; $display("FAIL rmid_strobes: got %b expected 0000", {bus.a, bus.b, bus.c, bus.busy});
        end
        nvec++;
        if (bus.seq_cnt !== 8'd0 || bus.pend_cnt !== 4'd0) begin
            nfail++; $display("FAIL rmid_cnt: got seq %0d pend %0d expected 0 0", bus.seq_cnt, bus.pend_cnt);
        end
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1'b1);
        nvec++;
        if (bus.a !== 1'b1 || bus.pend_cnt !== 4'd0) begin
            nfail++; $display("FAIL rmid_restart: got a %b pend %0d expected a 1 pend 0", bus.a, bus.pend_cnt);
        end
    endtask

    task automatic test_saturate();
        logic [2:0] exp_abc;
        int         exp_seq;
        do_reset();
        for (int n = 1; n <= 5; n++) begin
            for (int p = 0; p < 4; p++) begin
                bus2.start = (p == 0);
                @(posedge clk);
                #1;
                bus2.start = 1'b0;
                case (p)
                    0: exp_abc = 3'b100;
                    1: exp_abc = 3'b010;
                    2: exp_abc = 3'b001;
                    default: exp_abc = 3'b000;
                endcase
                nvec++;
                if ({bus2.a, bus2.b, bus2.c} !== exp_abc) begin
                    nfail++; $display("FAIL sat_abc[%0d.%0d]: got %b expected %b", n, p, {bus2.a, bus2.b, bus2.c}, exp_abc);
                end
            end
            exp_seq = (n > 3) ? 3 : n;
            nvec++;
            if (bus2.seq_cnt !== 2'(exp_seq)) begin
                nfail++; $display("FAIL sat_seq[%0d]: got %0d expected %0d", n, bus2.seq_cnt, exp_seq);
            end
        end
    endtask

    initial begin
        nvec       = 0;
        nfail      = 0;
        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus2.start = 1'b0;
        test_reset();
        test_single();
        test_queue();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
